// File: rtl/gray_to_bin_tracker.sv
// rtl/gray_to_bin_tracker.sv - Gray code stream decoder with single-step tracking
//
// Purpose:
//   Accepts N-bit Gray codes over a valid/ready handshake.
//   Registers the decoded binary value of each accepted code.
//   Classifies each accepted code against the previously accepted one:
//   repeat, legal +1/-1 step, or illegal multi-bit jump.
//   An illegal jump resynchronises the tracker to the new code.
//
// Optional feature:
//   GRAY_ERR_CNT_EN - adds err_count, a saturating 16-bit count of illegal steps.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   gray_in    in   N-bit Gray code sample
//   in_valid   in   gray_in is valid this cycle
//   in_ready   out  block can accept (combinational: !out_valid || out_ready)
//   bin_out    out  decoded binary of the last accepted code
//   out_valid  out  bin_out holds an unconsumed result
//   out_ready  in   consumer takes the result this cycle
//   dir_up     out  last step was +1 mod 2^N
//   step_err   out  last accepted code was an illegal step
//   locked     out  a reference code is held
//   err_count  out  illegal-step count (GRAY_ERR_CNT_EN only)

module gray_to_bin_tracker #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] gray_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] bin_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         dir_up,
    output logic         step_err,
    output logic         locked
`ifdef GRAY_ERR_CNT_EN
    ,
    output logic [15:0]  err_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] prev_gray_q, prev_gray_d;
    logic [N-1:0] bin_q, bin_d;
    logic         out_valid_q, out_valid_d;
    logic         dir_q, dir_d;
    logic         err_q, err_d;

    logic         accept;
    logic [N-1:0] new_bin;
    logic [N-1:0] inc_bin;
    logic [N-1:0] diff;
    logic         diff_zero;
    logic         diff_one;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Binary bit i is the XOR of all Gray bits at positions >= i.
    always_comb begin
        new_bin = '0;
        for (int i = 0; i < N; i++) begin
            new_bin[i] = ^(gray_in >> i);
        end
    end

    // bin_q always holds the decode of prev_gray_q, so it serves as the
    // previous binary value for direction detection.
    assign inc_bin   = bin_q + ONE;
    assign diff      = gray_in ^ prev_gray_q;
    assign diff_zero = (diff == '0);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign diff_one  = !diff_zero && ((diff & (diff - ONE)) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_gray_q <= '0;
            bin_q       <= '0;
            out_valid_q <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_gray_q <= prev_gray_d;
            bin_q       <= bin_d;
            out_valid_q <= out_valid_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_gray_d = prev_gray_q;
        bin_d       = bin_q;
        out_valid_d = out_valid_q;
        dir_d       = dir_q;
        err_d       = err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // An accept overrides the consume above, so accept+consume in one
        // cycle leaves out_valid set with the new result.
        if (accept) begin
            prev_gray_d = gray_in;
            bin_d       = new_bin;
            out_valid_d = 1'b1;
            dir_d       = 1'b0;
            err_d       = 1'b0;
            state_d     = TRACK;

            // In IDLE the first code is only a reference, never a step.
            if (state_q == TRACK) begin
                if (diff_one) begin
                    dir_d = (new_bin == inc_bin);
                end else if (!diff_zero) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    assign bin_out   = bin_q;
    assign out_valid = out_valid_q;
    assign dir_up    = dir_q;
    assign step_err  = err_q;
    assign locked    = (state_q == TRACK);

`ifdef GRAY_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        illegal_step;

    assign illegal_step = accept && (state_q == TRACK) && !diff_zero && !diff_one;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (illegal_step && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_gray_to_bin_tracker.sv
// tb/tb_gray_to_bin_tracker.sv - Self-checking bench for gray_to_bin_tracker (N=4)

module tb_gray_to_bin_tracker;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] gray_in;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] bin_out;
    logic         out_valid;
    logic         out_ready;
    logic         dir_up;
    logic         step_err;
    logic         locked;
`ifdef GRAY_ERR_CNT_EN
    logic [15:0]  err_count;
`endif

    gray_to_bin_tracker #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dir_up    (dir_up),
        .step_err  (step_err),
        .locked    (locked)
`ifdef GRAY_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  g;
        logic        ordy;
        logic        exp_ir;
        logic        exp_v;
        logic [3:0]  exp_bin;
        logic        exp_dir;
        logic        exp_err;
        logic        exp_lock;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vq[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [3:0] g, input logic ordy,
                       input logic ir, input logic v, input logic [3:0] b, input logic d,
                       input logic e, input logic l, input logic [15:0] c);
        vec_t x;
        x.rst = r; x.iv = iv; x.g = g; x.ordy = ordy;
        x.exp_ir = ir; x.exp_v = v; x.exp_bin = b; x.exp_dir = d;
        x.exp_err = e; x.exp_lock = l; x.exp_cnt = c;
        vq.push_back(x);
    endtask

    task automatic drive(input logic r, input logic iv, input logic [3:0] g, input logic ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        gray_in   = g;
        out_ready = ordy;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [3:0] b,
                              input logic d, input logic e, input logic l, input logic [15:0] c);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, " bin_out"},   32'(bin_out),   32'(b));
        chk({tag, " dir_up"},    32'(dir_up),    32'(d));
        chk({tag, " step_err"},  32'(step_err),  32'(e));
        chk({tag, " locked"},    32'(locked),    32'(l));
`ifdef GRAY_ERR_CNT_EN
        chk({tag, " err_count"}, 32'(err_count), 32'(c));
`else
        if (c != c) chk({tag, " err_count"}, 32'(c), 32'(c));
`endif
    endtask

    // Reference model: binary value is the running XOR of Gray bits from the MSB.
    function automatic int gray_decode(input int g);
        int b;
        int bit_acc;
        b = 0;
        bit_acc = 0;
        for (int k = N - 1; k >= 0; k--) begin
            bit_acc = bit_acc ^ ((g >> k) & 1);
            b = b | (bit_acc << k);
        end
        return b;
    endfunction

    int m_lock, m_prev, m_v, m_bin, m_dir, m_err, m_cnt;

    task automatic model_step(input int r, input int iv, input int g, input int ordy);
        int acc;
        int nb;
        int d;
        acc = iv && (!m_v || ordy);
        if (r) begin
            m_lock = 0; m_prev = 0; m_v = 0; m_bin = 0; m_dir = 0; m_err = 0; m_cnt = 0;
        end else if (acc) begin
            nb = gray_decode(g);
            m_dir = 0;
            m_err = 0;
            if (m_lock) begin
                d = $countones(4'(g ^ m_prev));
                if (d == 1) begin
                    m_dir = (nb == ((m_bin + 1) % (1 << N)));
                end else if (d >= 2) begin
                    m_err = 1;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
            end
            m_prev = g;
            m_bin  = nb;
            m_v    = 1;
            m_lock = 1;
        end else if (m_v && ordy) begin
            m_v = 0;
        end
    endtask

    initial begin
        vec_t x;
        int   r, iv, g, ordy, sel;

        rst = 1'b1; in_valid = 1'b0; gray_in = '0; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Plain sequence with consumer always ready
        add(0,1,4'b0000,1, 1,1, 0,0,0,1,0);
        add(0,1,4'b0001,1, 1,1, 1,1,0,1,0);
        add(0,1,4'b0011,1, 1,1, 2,1,0,1,0);
        add(0,1,4'b0010,1, 1,1, 3,1,0,1,0);
        add(1,0,4'b0000,1, 1,0, 0,0,0,0,0);
        // Wrap both directions
        add(0,1,4'b1000,1, 1,1,15,0,0,1,0);
        add(0,1,4'b0000,1, 1,1, 0,1,0,1,0);
        add(0,1,4'b1000,1, 1,1,15,0,0,1,0);
        add(1,0,4'b0000,1, 1,0, 0,0,0,0,0);
        // Illegal step then resync
        add(0,1,4'b0001,1, 1,1, 1,0,0,1,0);
        add(0,1,4'b0111,1, 1,1, 5,0,1,1,1);
        add(0,1,4'b0101,1, 1,1, 6,1,0,1,1);
        add(1,0,4'b0000,1, 1,0, 0,0,0,0,0);
        // Backpressure
        add(0,1,4'b0011,1, 1,1, 2,0,0,1,0);
        add(0,1,4'b0010,0, 0,1, 2,0,0,1,0);
        add(0,1,4'b0010,0, 0,1, 2,0,0,1,0);
        add(0,1,4'b0010,0, 0,1, 2,0,0,1,0);
        add(0,1,4'b0010,1, 1,1, 3,1,0,1,0);
        add(0,0,4'b0000,1, 1,0, 3,1,0,1,0);
        // Reset mid-stream with a pending result, then a far code as first
        add(0,1,4'b0000,1, 1,1, 0,0,0,1,0);
        add(0,1,4'b0000,0, 0,1, 0,0,0,1,0);
        add(1,1,4'b1111,0, 0,0, 0,0,0,0,0);
        add(0,1,4'b1111,1, 1,1,10,0,0,1,0);

        for (int i = 0; i < vq.size(); i++) begin
            x = vq[i];
            drive(x.rst, x.iv, x.g, x.ordy);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(x.exp_ir));
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), x.exp_v, x.exp_bin, x.exp_dir,
                       x.exp_err, x.exp_lock, x.exp_cnt);
        end

        // Randomised traffic against the reference model
        drive(1, 0, 0, 1);
        model_step(1, 0, 0, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 99) < 3);
            iv   = ($urandom_range(0, 99) < 80);
            ordy = ($urandom_range(0, 99) < 70);
            sel  = $urandom_range(0, 99);
            if (sel < 60)      g = m_prev ^ (1 << $urandom_range(0, N - 1));
            else if (sel < 75) g = m_prev;
            else               g = $urandom_range(0, (1 << N) - 1);
            drive(r[0], iv[0], 4'(g), ordy[0]);
            chk($sformatf("rnd%0d in_ready", i), 32'(in_ready), 32'(!m_v || ordy));
            model_step(r, iv, g, ordy);
            @(posedge clk);
            #1;
            check_outs($sformatf("rnd%0d", i), m_v[0], 4'(m_bin), m_dir[0], m_err[0],
                       m_lock[0], 16'(m_cnt));
        end

`ifdef GRAY_ERR_CNT_EN
        // Saturation: first code as reference, then 65540 illegal jumps
        drive(1, 0, 4'b0000, 1);
        @(posedge clk);
        drive(0, 1, 4'b0000, 1);
        for (int i = 1; i <= 65540; i++) begin
            drive(0, 1, (i % 2 == 1) ? 4'b0011 : 4'b0000, 1);
            if (i == 101) chk("sat mid err_count", 32'(err_count), 32'd100);
            if (i == 65536) chk("sat pre err_count", 32'(err_count), 32'hFFFF);
        end
        @(posedge clk);
        #1;
        chk("sat final err_count", 32'(err_count), 32'hFFFF);
        chk("sat final step_err", 32'(step_err), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
